vproc_mem_responder: RTL and testbench
======================================

// Module: vproc_mem_responder
// PURPOSE
// - Memory-side responder for the vector core's data port (req/addr/we/be/wdata -> rvalid/err/rdata).
// - Sits between the vector core and storage; it replaces the stub path through mmu/sram.
// - Serves a local word-addressed SRAM and a small timer MMIO window, which drives digitalTimer.
// - Accepts one request per cycle (no grant signal) and answers in order after a fixed latency.
// PARAMETERS
// - MEM_W       32          data width in bits; must be a multiple of 32
// - SRAM_WORDS  1024        SRAM depth in MEM_W words; must be a power of 2
// - LATENCY     1           request-to-response cycles, legal range 1..4
// PORTS
// - clk              in   1         clock; all state updates on the rising edge
// - rst              in   1         asynchronous, active-low reset
// - mem_req_i        in   1         request valid; accepted on every cycle it is high
// - mem_addr_i       in   32        byte address
// - mem_we_i         in   1         1 = write, 0 = read
// - mem_be_i         in   MEM_W/8   byte enables (writes only)
// - mem_wdata_i      in   MEM_W     write data
// - mem_rvalid_o     out  1         response valid; one per accepted request, reads and writes alike
// - mem_err_o        out  1         response error; qualified by mem_rvalid_o
// - mem_rdata_o      out  MEM_W     read data; 0 for writes and for errors
// - timer_is_high_i  in   1         status from digitalTimer
// - timer_set_val_o  out  32        timer reload value register
// - set_timer_o      out  1         one-cycle pulse that loads the timer
// BEHAVIOUR
// - Reset (rst=0, asynchronous):
//   - mem_rvalid_o=0, mem_err_o=0, mem_rdata_o=0, timer_set_val_o=0, set_timer_o=0.
//   - Response pipeline is flushed; in-flight responses are dropped and never issued.
//   - SRAM contents are not reset and are undefined after power-up.
// - Address decode (in the acceptance cycle):
//   - SRAM hit: SRAM_BASE <= addr < SRAM_BASE + SRAM_WORDS*MEM_W/8.
//   - TIMER hit: addr[31:4] == TIMER_BASE[31:4].
//   - Anything else is an error.
// - Alignment: addr[$clog2(MEM_W/8)-1:0] != 0 is an error; be is always word-granular.
// - SRAM write: bytes with be[i]=1 are updated at the acceptance edge. be=0 is a legal no-op and
//   still returns an rvalid.
// - SRAM read: word at index (addr-SRAM_BASE)>>log2(MEM_W/8), sampled at the acceptance edge.
//   - A read accepted in cycle N+1 after a write in cycle N returns the written data.
// - TIMER regs (word offset addr[3:2]):
//   - 0: SET_VAL, RW, full 32 bits; writes honour be.
//   - 1: CTRL.
//     - Write with be[0]=1 and wdata[0]=1 -> set_timer_o=1 for exactly the cycle after acceptance.
//     - Read returns {31'b0, timer_is_high_i} sampled at acceptance.
//   - 2, 3: error.
//   - When MEM_W > 32, the timer regs occupy bits [31:0]; upper bits read 0.
// - Error response: no state change, mem_err_o=1, mem_rdata_o=0.
// - Latency: a request accepted at edge N produces mem_rvalid_o=1 during cycle N+LATENCY, for
//   exactly 1 cycle.
//   - Back-to-back requests give back-to-back responses, in order.
// - Outputs are registered; there is no combinational path from inputs to outputs.
// - Inputs other than mem_req_i are ignored when mem_req_i=0.
// - A SET_VAL write and a CTRL pulse write in consecutive cycles: the pulse sees the new SET_VAL.
// STRUCTURE
// - Package vproc_mem_pkg holds:
//   - SRAM_BASE = 32'h0000_0000 and TIMER_BASE = 32'h8000_0000.
//   - Timer register offset constants.
//   - typedef resp_t {logic valid; logic err; logic [MEM_W-1:0] rdata;}.
// - Sub-module vproc_mem_resp_pipe: resp_t delay line of depth LATENCY-1, flushed by rst.
//   - The first stage is the registered decode/access result held in vproc_mem_responder itself.
// - The SRAM is an inferred array with byte-enable writes.
// TESTING
// - LATENCY=1: write 0xDEADBEEF to 0x10 with be=F, then read 0x10 in the next cycle -> the read
//   response is 0xDEADBEEF, one cycle after acceptance, err=0.
// - Partial write: be=4'b0100, wdata=0x00AA0000 to 0x10 -> a read of 0x10 returns 0xDEAABEEF.
// - Error cases -> each gives rvalid=1, err=1, rdata=0, and no state change:
//   - unmapped read at 0x4000_0000
//   - misaligned read at 0x12
//   - read at TIMER_BASE+0x8
// - Timer path:
//   - write 0x64 to TIMER_BASE+0 -> timer_set_val_o=0x64;
//   - write 1 to TIMER_BASE+4 -> set_timer_o high for exactly 1 cycle;
//   - read TIMER_BASE+4 with timer_is_high_i=1 -> rdata=1.
// - LATENCY=3, 8 back-to-back reads of 8 preloaded words -> 8 in-order responses in consecutive
//   cycles, the first at acceptance+3.
// - rst asserted with 2 responses in flight -> outputs are 0 immediately, and no rvalid is ever
//   issued for those requests.

Source files
------------

// File: rtl/vproc_mem_pkg.sv
// Shared constants for the vector-core memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vproc_mem_pkg;

    // Address map: the SRAM window starts at SRAM_BASE, and the timer occupies a 16-byte window.
    localparam logic [31:0] SRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] TIMER_BASE = 32'h8000_0000;

    // Timer register word offsets, taken from addr[3:2].
    localparam logic [1:0] TMR_SET_VAL = 2'd0;
    localparam logic [1:0] TMR_CTRL    = 2'd1;

    // The response record is declared as a typedef inside vproc_mem_responder.
    // Its rdata field is sized by that module's MEM_W parameter, so a package can't hold a fixed-width copy.

endpackage

// File: rtl/vproc_mem_resp_pipe.sv
// Delay line for response records: DEPTH register stages (0 = wire-through).
// Latency: DEPTH cycles.
// Backpressure: none; one record enters and one leaves every cycle. Reset flushes every stage.
module vproc_mem_resp_pipe #(
    parameter type T     = logic,
    parameter int  DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  T     in_dat,
    output T     out_dat
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_dat = in_dat;
    end else begin : g_pipe
        T stage_q [DEPTH];

        // Shift records one stage per cycle; reset drops anything in flight.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= in_dat;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign out_dat = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vproc_mem_responder.sv
// Data-port responder for the vector core: local SRAM plus timer MMIO window.
// Latency: LATENCY cycles from acceptance to rvalid, fixed, with responses returned in order.
// Backpressure: none; a request is accepted on every cycle that mem_req_i is high.
module vproc_mem_responder
    import vproc_mem_pkg::*;
#(
    parameter int MEM_W      = 32,
    parameter int SRAM_WORDS = 1024,
    parameter int LATENCY    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_we_i,
    input  logic [MEM_W/8-1:0] mem_be_i,
    input  logic [MEM_W-1:0]   mem_wdata_i,
    output logic               mem_rvalid_o,
    output logic               mem_err_o,
    output logic [MEM_W-1:0]   mem_rdata_o,
    input  logic               timer_is_high_i,
    output logic [31:0]        timer_set_val_o,
    output logic               set_timer_o
);

    localparam int          BE_W       = MEM_W / 8;
    localparam int          ADDR_LSB   = $clog2(BE_W);
    localparam int          IDX_W      = $clog2(SRAM_WORDS);
    localparam logic [32:0] SRAM_BYTES = 33'(SRAM_WORDS * BE_W);

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } resp_t;

    logic [MEM_W-1:0] sram_q [SRAM_WORDS];
    logic [31:0]      set_val_q;
    logic             set_timer_q;
    resp_t            resp_q;
    resp_t            resp_d;
    resp_t            pipe_out;

    logic [32:0]      sram_off;
    logic [IDX_W-1:0] sram_idx;
    logic             misaligned;
    logic             sram_hit;
    logic             timer_hit;
    logic [1:0]       timer_reg;
    logic             err_d;
    logic             sram_wr;
    logic             setval_wr;
    logic             pulse_wr;
    logic [MEM_W-1:0] rd_word;

    // The 33-bit subtraction makes an address below SRAM_BASE borrow into bit 32, so it fails the range test.
    assign sram_off   = {1'b0, mem_addr_i} - {1'b0, SRAM_BASE};
    assign sram_hit   = sram_off < SRAM_BYTES;
    assign sram_idx   = sram_off[ADDR_LSB +: IDX_W];
    assign misaligned = mem_addr_i[ADDR_LSB-1:0] != '0;
    assign timer_hit  = mem_addr_i[31:4] == TIMER_BASE[31:4];
    assign timer_reg  = mem_addr_i[3:2];

    // Decode the request, qualify the writes, and build this cycle's response record.
    always_comb begin
        err_d     = misaligned ||
                    !(sram_hit || (timer_hit && (timer_reg == TMR_SET_VAL || timer_reg == TMR_CTRL)));
        sram_wr   = mem_req_i && mem_we_i && sram_hit && !err_d;
        setval_wr = mem_req_i && mem_we_i && timer_hit && (timer_reg == TMR_SET_VAL) && !err_d;
        pulse_wr  = mem_req_i && mem_we_i && timer_hit && (timer_reg == TMR_CTRL) && !err_d &&
                    mem_be_i[0] && mem_wdata_i[0];

        rd_word = '0;
        if (sram_hit)
            rd_word = sram_q[sram_idx];
        else if (timer_hit && timer_reg == TMR_SET_VAL)
            rd_word = MEM_W'(set_val_q);
        else if (timer_hit && timer_reg == TMR_CTRL)
            rd_word = MEM_W'(timer_is_high_i);

        resp_d.valid = mem_req_i;
        resp_d.err   = mem_req_i && err_d;
        resp_d.rdata = (mem_req_i && !mem_we_i && !err_d) ? rd_word : '0;
    end

    // SRAM byte-lane writes. The array has no reset because its contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (sram_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be_i[b]) sram_q[sram_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
            end
        end
    end

    // Timer registers. The load pulse lasts one cycle, in the cycle after the CTRL write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_val_q   <= '0;
            set_timer_q <= 1'b0;
        end else begin
            set_timer_q <= pulse_wr;
            if (setval_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_i[b]) set_val_q[b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // First response stage: the registered result of the access, taken at the acceptance edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) resp_q <= '0;
        else      resp_q <= resp_d;
    end

    vproc_mem_resp_pipe #(
        .T     (resp_t),
        .DEPTH (LATENCY - 1)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_dat  (resp_q),
        .out_dat (pipe_out)
    );

    assign mem_rvalid_o    = pipe_out.valid;
    assign mem_err_o       = pipe_out.err;
    assign mem_rdata_o     = pipe_out.rdata;
    assign timer_set_val_o = set_val_q;
    assign set_timer_o     = set_timer_q;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Directed bench: a LATENCY=1 and a LATENCY=3 responder share one request stream.
// Latency: checks response timing against hand-computed cycle positions.
// Backpressure: n/a (the responder accepts a request every cycle).
module tb_vproc_mem_responder;

    localparam logic [31:0] TB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        timer_is_high;

    logic        rv1, err1, st1;
    logic [31:0] rd1, tsv1;
    logic        rv3, err3, st3;
    logic [31:0] rd3, tsv3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vproc_mem_responder #(.MEM_W(32), .SRAM_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rv1), .mem_err_o(err1),
        .mem_rdata_o(rd1), .timer_is_high_i(timer_is_high), .timer_set_val_o(tsv1),
        .set_timer_o(st1)
    );

    vproc_mem_responder #(.MEM_W(32), .SRAM_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rv3), .mem_err_o(err3),
        .mem_rdata_o(rd3), .timer_is_high_i(timer_is_high), .timer_set_val_o(tsv3),
        .set_timer_o(st3)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // Checks the LATENCY=1 response visible right now.
    task automatic check_resp1(input string tag, input logic v, input logic e, input logic [31:0] d);
        check_val({tag, "_vld"}, {31'b0, rv1}, {31'b0, v});
        check_val({tag, "_err"}, {31'b0, err1}, {31'b0, e});
        check_val({tag, "_dat"}, rd1, d);
    endtask

    // Drive one request. Return 1ns after its acceptance edge, with the bus idle.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    logic [31:0] err_addrs [3];
    logic        v1s [12];
    logic        v3s [12];
    logic [31:0] d1s [12];
    logic [31:0] d3s [12];
    int          seen;

    initial begin
        rst = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; timer_is_high = 1'b0;
        err_addrs[0] = 32'h4000_0000;
        err_addrs[1] = 32'h0000_0012;
        err_addrs[2] = TB + 32'h8;

        #12;
        check_val("rst_rvalid1", {31'b0, rv1}, 32'd0);
        check_val("rst_err1",    {31'b0, err1}, 32'd0);
        check_val("rst_rdata1",  rd1, 32'd0);
        check_val("rst_setval1", tsv1, 32'd0);
        check_val("rst_pulse1",  {31'b0, st1}, 32'd0);
        check_val("rst_rvalid3", {31'b0, rv3}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        // Full write, then a read of the same word in the next cycle.
        issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        check_resp1("wr_full", 1'b1, 1'b0, 32'h0);
        issue(32'h10, 1'b0, 4'h0, 32'h0);
        check_resp1("rd_full", 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle(1);
        check_val("rvalid_one_cycle", {31'b0, rv1}, 32'd0);

        // be=0 write is a no-op, but it still responds.
        issue(32'h10, 1'b1, 4'h0, 32'h1234_5678);
        check_resp1("wr_be0", 1'b1, 1'b0, 32'h0);

        // Partial write to byte lane 2.
        issue(32'h10, 1'b1, 4'b0100, 32'h00AA_0000);
        issue(32'h10, 1'b0, 4'h0, 32'h0);
        check_resp1("rd_partial", 1'b1, 1'b0, 32'hDEAA_BEEF);

        // Error reads.
        for (int i = 0; i < 3; i++) begin
            issue(err_addrs[i], 1'b0, 4'h0, 32'h0);
            check_resp1($sformatf("err_rd%0d", i), 1'b1, 1'b1, 32'h0);
        end

        // Error writes must not change any state.
        issue(32'h12, 1'b1, 4'hF, 32'hFFFF_FFFF);
        check_resp1("err_wr_mis", 1'b1, 1'b1, 32'h0);
        issue(TB + 32'h8, 1'b1, 4'hF, 32'hFFFF_FFFF);
        check_resp1("err_wr_tmr", 1'b1, 1'b1, 32'h0);
        check_val("err_wr_setval", tsv1, 32'h0);
        issue(32'h10, 1'b0, 4'h0, 32'h0);
        check_resp1("rd_after_err", 1'b1, 1'b0, 32'hDEAA_BEEF);

        // Timer: load SET_VAL, then pulse in the next cycle. The pulse sees the new value.
        issue(TB, 1'b1, 4'hF, 32'h64);
        check_val("setval_wr", tsv1, 32'h64);
        check_val("no_pulse_setval", {31'b0, st1}, 32'd0);
        issue(TB + 32'h4, 1'b1, 4'h1, 32'h1);
        check_val("pulse_hi", {31'b0, st1}, 32'd1);
        check_val("pulse_setval", tsv1, 32'h64);
        idle(1);
        check_val("pulse_lo", {31'b0, st1}, 32'd0);
        issue(TB + 32'h4, 1'b1, 4'h1, 32'h0);
        check_val("ctrl_wr0_nopulse", {31'b0, st1}, 32'd0);
        timer_is_high = 1'b1;
        issue(TB + 32'h4, 1'b0, 4'h0, 32'h0);
        check_resp1("ctrl_rd_hi", 1'b1, 1'b0, 32'h1);
        timer_is_high = 1'b0;
        issue(TB + 32'h4, 1'b0, 4'h0, 32'h0);
        check_resp1("ctrl_rd_lo", 1'b1, 1'b0, 32'h0);
        issue(TB + 32'h1, 1'b0, 4'h0, 32'h0);
        check_resp1("tmr_misaligned", 1'b1, 1'b1, 32'h0);
        issue(TB, 1'b1, 4'b0010, 32'h0000_1200);
        issue(TB, 1'b0, 4'h0, 32'h0);
        check_resp1("setval_rd", 1'b1, 1'b0, 32'h1264);

        // Preload 8 words, then issue 8 back-to-back reads.
        for (int i = 0; i < 8; i++) issue(32'h100 + 32'(i) * 4, 1'b1, 4'hF, word_of(i));
        idle(4);
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                req = 1'b1; addr = 32'h100 + 32'(k) * 4; we = 1'b0;
            end else begin
                req = 1'b0; addr = '0;
            end
            @(posedge clk);
            #1;
            v1s[k] = rv1; d1s[k] = rd1;
            v3s[k] = rv3; d3s[k] = rd3;
        end
        req = 1'b0; addr = '0;
        for (int k = 0; k < 12; k++) begin
            check_val($sformatf("b2b_l1_vld%0d", k), {31'b0, v1s[k]}, {31'b0, (k < 8)});
            check_val($sformatf("b2b_l1_dat%0d", k), d1s[k], (k < 8) ? word_of(k) : 32'h0);
            check_val($sformatf("b2b_l3_vld%0d", k), {31'b0, v3s[k]}, {31'b0, (k >= 2 && k < 10)});
            check_val($sformatf("b2b_l3_dat%0d", k), d3s[k], (k >= 2 && k < 10) ? word_of(k - 2) : 32'h0);
        end

        // Reset with the LATENCY=3 pipe holding one visible and two in-flight responses.
        idle(4);
        issue(32'h100, 1'b0, 4'h0, 32'h0);
        issue(32'h104, 1'b0, 4'h0, 32'h0);
        issue(32'h108, 1'b0, 4'h0, 32'h0);
        check_val("pre_rst_l3_vld", {31'b0, rv3}, 32'd1);
        check_val("pre_rst_l3_dat", rd3, word_of(0));
        check_val("pre_rst_l1_dat", rd1, word_of(2));
        rst = 1'b0;
        #1;
        check_val("rst_now_l3_vld", {31'b0, rv3}, 32'd0);
        check_val("rst_now_l3_dat", rd3, 32'd0);
        check_val("rst_now_l1_vld", {31'b0, rv1}, 32'd0);
        check_val("rst_now_l1_dat", rd1, 32'd0);
        check_val("rst_now_setval", tsv1, 32'd0);
        idle(2);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (rv3 || rv1) seen++;
        end
        check_val("flushed_no_rvalid", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
